// File: rtl/cache_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_req_arbiter_pkg
// Description : Shared command codes and FSM state encoding for the cache
//               request arbiter and the cache it fronts.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_req_arbiter_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_WAIT  = 3'd1,
    ST_WR_PUSH  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cache_req_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_req_arbiter_rr_arbiter
// Description : Combinational round-robin pick: first set request bit at or
//               above the pointer, wrapping. Pointer storage lives in parent.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_req_arbiter_rr_arbiter
  import cache_req_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_any
);

  // Scan NREQ candidates starting at ptr; the first pending one wins.
  always_comb begin : p_pick
    logic [IDXW-1:0] cand;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDXW'((int'(ptr) + i) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any   = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_req_arbiter
// Description : Round-robin sharing of one cache port between NREQ
//               requesters, one transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_req_arbiter
  import cache_req_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 12,
  parameter int PIDW = 4,
  parameter int TMO  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_cmd,
  input  logic [DW*NREQ-1:0]   req_data,
  input  logic [PIDW*NREQ-1:0] req_pid,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_fault,
  output logic [1:0]           c_cmd,
  output logic [DW-1:0]        c_datain,
  output logic [PIDW-1:0]      c_pid,
  output logic                 c_datavalid,
  input  logic                 c_wd,
  input  logic                 c_pagefault,
  input  logic [DW-1:0]        c_dataout,
  input  logic                 c_outvalid,
  output logic                 busy
);

  localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]      TMO_LAST = 8'(TMO - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [DW-1:0]   data_q, data_d;
  logic [PIDW-1:0] pid_q, pid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic [7:0]      tmo_cnt_q, tmo_cnt_d;

  logic [NREQ-1:0] gnt_oh;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_any;
  logic            tmo_hit;

  logic [1:0]      cmd_arr  [NREQ];
  logic [DW-1:0]   data_arr [NREQ];
  logic [PIDW-1:0] pid_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign cmd_arr[i]  = req_cmd[2*i +: 2];
    assign data_arr[i] = req_data[DW*i +: DW];
    assign pid_arr[i]  = req_pid[PIDW*i +: PIDW];
  end

  cache_req_arbiter_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Last waiting cycle before the cache is given up on.
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  // State and owner registers; reset drops any transaction without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      data_q      <= '0;
      pid_q       <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      data_q      <= data_d;
      pid_q       <= pid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  // Next state: grant/latch in IDLE, walk the cache handshake, stage response.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    data_d      = data_q;
    pid_d       = pid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          owner_d     = gnt_idx;
          data_d      = data_arr[gnt_idx];
          pid_d       = pid_arr[gnt_idx];
          rr_ptr_d    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          tmo_cnt_d   = '0;
          rsp_data_d  = '0;
          rsp_fault_d = 1'b0;
          case (cmd_arr[gnt_idx])
            CMD_WRITE: state_d = ST_WR_WAIT;
            CMD_READ:  state_d = ST_RD_ISSUE;
            default: begin
              state_d     = ST_RESP;
              rsp_fault_d = 1'b1;
            end
          endcase
        end
      end
      ST_WR_WAIT: begin
        if (c_wd) begin
          state_d = ST_WR_PUSH;
        end else if (tmo_hit) begin
          state_d     = ST_RESP;
          rsp_fault_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_WR_PUSH: begin
        state_d     = ST_RESP;
        rsp_fault_d = 1'b0;
        rsp_data_d  = '0;
      end
      ST_RD_ISSUE: begin
        state_d   = ST_RD_WAIT;
        tmo_cnt_d = '0;
      end
      ST_RD_WAIT: begin
        // A page fault outranks data returned in the same cycle.
        if (c_pagefault) begin
          state_d     = ST_RESP;
          rsp_fault_d = 1'b1;
          rsp_data_d  = '0;
        end else if (c_outvalid) begin
          state_d     = ST_RESP;
          rsp_fault_d = 1'b0;
          rsp_data_d  = c_dataout;
        end else if (tmo_hit) begin
          state_d     = ST_RESP;
          rsp_fault_d = 1'b1;
          rsp_data_d  = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; cache bus and response are zero when unused.
  always_comb begin
    req_ack     = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    rsp_fault   = 1'b0;
    c_cmd       = CMD_IDLE;
    c_datain    = '0;
    c_pid       = '0;
    c_datavalid = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (!rst) req_ack = gnt_oh;
      end
      ST_WR_WAIT: begin
        c_cmd    = CMD_WRITE;
        c_datain = data_q;
        c_pid    = pid_q;
      end
      ST_WR_PUSH: begin
        c_cmd       = CMD_WRITE;
        c_datain    = data_q;
        c_pid       = pid_q;
        c_datavalid = 1'b1;
      end
      ST_RD_ISSUE, ST_RD_WAIT: begin
        c_cmd    = CMD_READ;
        c_datain = data_q;
        c_pid    = pid_q;
      end
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_data           = rsp_data_q;
        rsp_fault          = rsp_fault_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_req_arbiter
// Description : Self-checking bench for cache_req_arbiter with a behavioural
//               cache responder and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_req_arbiter;

  localparam int NREQ   = 4;
  localparam int DW     = 12;
  localparam int PIDW   = 4;
  localparam int TMO    = 255;
  localparam int BUDGET = TMO + 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_cmd;
  logic [DW*NREQ-1:0]   req_data;
  logic [PIDW*NREQ-1:0] req_pid;
  logic [NREQ-1:0]      req_ack, rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_fault;
  logic [1:0]           c_cmd;
  logic [DW-1:0]        c_datain;
  logic [PIDW-1:0]      c_pid;
  logic                 c_datavalid, c_wd, c_pagefault, c_outvalid, busy;
  logic [DW-1:0]        c_dataout;

  int checks = 0;
  int errors = 0;

  cache_req_arbiter #(.NREQ(NREQ), .DW(DW), .PIDW(PIDW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_data(req_data), .req_pid(req_pid), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .c_cmd(c_cmd), .c_datain(c_datain), .c_pid(c_pid),
    .c_datavalid(c_datavalid), .c_wd(c_wd), .c_pagefault(c_pagefault),
    .c_dataout(c_dataout), .c_outvalid(c_outvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int n = 0;
    int idx = -2;
    for (int i = 0; i < NREQ; i++) if (v[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -2;
  endfunction

  task automatic set_req(input int idx, input logic [1:0] cmd,
                         input logic [DW-1:0] data, input logic [PIDW-1:0] pid);
    req_cmd[idx*2 +: 2]       = cmd;
    req_data[idx*DW +: DW]    = data;
    req_pid[idx*PIDW +: PIDW] = pid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    c_wd = 1'b0; c_outvalid = 1'b0; c_pagefault = 1'b0; c_dataout = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drive the cache side for one transaction and record what the DUT did.
  // A delay of 0 means the cache line is held high from the start.
  task automatic run_txn(input int wd_dly, input int rd_dly, input bit pf, input bit ov,
                         input logic [DW-1:0] rdata,
                         output int ack_idx, output int ack_cyc, output int cmd_cyc,
                         output int rsp_cyc, output int rsp_idx,
                         output logic [DW-1:0] rdat, output logic flt,
                         output int dv_cnt, output bit dv_b2b,
                         output logic [DW-1:0] din, output logic [PIDW-1:0] pid,
                         output int cmd_cycles);
    int k;
    bit done, prev_dv, rd_go;
    logic [1:0] last_cmd;
    ack_idx = -1; ack_cyc = -1; cmd_cyc = -1; rsp_cyc = -1; rsp_idx = -1;
    rdat = '0; flt = 1'b0; dv_cnt = 0; dv_b2b = 1'b0; din = '0; pid = '0;
    cmd_cycles = 0; k = 0; done = 1'b0; prev_dv = 1'b0; last_cmd = 2'b00;
    c_dataout   = rdata;
    c_wd        = (wd_dly == 0);
    c_outvalid  = (rd_dly == 0) && ov;
    c_pagefault = (rd_dly == 0) && pf;
    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        if (ack_idx == -1) begin ack_idx = onehot_idx(req_ack); ack_cyc = cyc; end
        else ack_idx = -3;
      end
      if (c_cmd != 2'b00) begin
        if (cmd_cyc == -1) begin cmd_cyc = cyc; din = c_datain; pid = c_pid; end
        cmd_cycles++;
        k++;
        last_cmd = c_cmd;
      end
      if (c_datavalid) begin
        dv_cnt++;
        if (prev_dv) dv_b2b = 1'b1;
        din = c_datain;
        pid = c_pid;
      end
      prev_dv = c_datavalid;
      if (rsp_valid != '0) begin
        rsp_idx = onehot_idx(rsp_valid); rsp_cyc = cyc;
        rdat = rsp_data; flt = rsp_fault; done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ack_cyc == cyc && ack_idx >= 0) req_valid[ack_idx] = 1'b0;
      if (done) begin
        c_wd = 1'b0; c_outvalid = 1'b0; c_pagefault = 1'b0;
      end else begin
        c_wd        = (wd_dly == 0) || (last_cmd == 2'b10 && k >= wd_dly);
        rd_go       = (rd_dly == 0) || (last_cmd == 2'b01 && k >= rd_dly);
        c_outvalid  = rd_go && ov;
        c_pagefault = rd_go && pf;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_cmd = '0; req_data = '0; req_pid = '0;
    c_wd = 1'b0; c_outvalid = 1'b0; c_pagefault = 1'b0; c_dataout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ack !== '0) begin errors++; $display("FAIL reset_ack: got %h want 0", req_ack); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %h want 0", rsp_valid); end
    checks++; if (c_cmd !== 2'b00) begin errors++; $display("FAIL reset_c_cmd: got %b want 00", c_cmd); end
    checks++; if (c_datavalid !== 1'b0) begin errors++; $display("FAIL reset_datavalid: got %b want 0", c_datavalid); end
    checks++; if ({c_datain, c_pid, rsp_data, rsp_fault} !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", {c_datain, c_pid, rsp_data, rsp_fault}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single_write();
    int ai, ac, cc, rc, ri, dn, cmc; bit b2b; logic [DW-1:0] rd, di; logic f; logic [PIDW-1:0] pi;
    set_req(0, 2'b10, 12'd100, 4'd4);
    req_valid = 4'b0001;
    run_txn(2, 0, 1'b0, 1'b0, '0, ai, ac, cc, rc, ri, rd, f, dn, b2b, di, pi, cmc);
    checks++; if (ai !== 0) begin errors++; $display("FAIL wr_ack: got %0d want 0", ai); end
    checks++; if (ac !== 0 || cc !== 1) begin errors++; $display("FAIL wr_grant_latency: got ack %0d cmd %0d want 0 1", ac, cc); end
    checks++; if (dn !== 1 || b2b) begin errors++; $display("FAIL wr_datavalid_count: got %0d want 1", dn); end
    checks++; if (di !== 12'd100 || pi !== 4'd4) begin errors++; $display("FAIL wr_payload: got %0d/%0d want 100/4", di, pi); end
    checks++; if (ri !== 0 || f !== 1'b0 || rd !== '0) begin errors++; $display("FAIL wr_rsp: got idx %0d fault %b data %h want 0 0 0", ri, f, rd); end
  endtask

  task automatic test_read_hit();
    int ai, ac, cc, rc, ri, dn, cmc; bit b2b; logic [DW-1:0] rd, di; logic f; logic [PIDW-1:0] pi;
    set_req(2, 2'b01, 12'h05F, 4'd5);
    req_valid = 4'b0100;
    run_txn(0, 3, 1'b0, 1'b1, 12'h3A7, ai, ac, cc, rc, ri, rd, f, dn, b2b, di, pi, cmc);
    checks++; if (ai !== 2 || cc !== ac + 1) begin errors++; $display("FAIL rd_ack: got %0d at %0d cmd %0d want 2 one cycle before cmd", ai, ac, cc); end
    checks++; if (di !== 12'h05F || pi !== 4'd5) begin errors++; $display("FAIL rd_addr: got %h/%0d want 05f/5", di, pi); end
    checks++; if (ri !== 2 || rd !== 12'h3A7 || f !== 1'b0) begin errors++; $display("FAIL rd_rsp: got idx %0d data %h fault %b want 2 3a7 0", ri, rd, f); end
    checks++; if (dn !== 0) begin errors++; $display("FAIL rd_no_datavalid: got %0d want 0", dn); end
  endtask

  task automatic test_page_fault();
    int ai, ac, cc, rc, ri, dn, cmc; bit b2b; logic [DW-1:0] rd, di; logic f; logic [PIDW-1:0] pi;
    set_req(3, 2'b01, 12'h0AB, 4'd9);
    req_valid = 4'b1000;
    run_txn(0, 1, 1'b1, 1'b1, 12'h555, ai, ac, cc, rc, ri, rd, f, dn, b2b, di, pi, cmc);
    checks++; if (ri !== 3 || f !== 1'b1 || rd !== '0) begin errors++; $display("FAIL pf_rsp: got idx %0d fault %b data %h want 3 1 0", ri, f, rd); end
  endtask

  task automatic test_illegal();
    int ai, ac, cc, rc, ri, dn, cmc; bit b2b; logic [DW-1:0] rd, di; logic f; logic [PIDW-1:0] pi;
    set_req(1, 2'b11, 12'hFFF, 4'd1);
    req_valid = 4'b0010;
    run_txn(0, 0, 1'b0, 1'b1, 12'h777, ai, ac, cc, rc, ri, rd, f, dn, b2b, di, pi, cmc);
    checks++; if (ai !== 1 || rc !== ac + 1) begin errors++; $display("FAIL ill_timing: got ack %0d at %0d rsp at %0d want 1 then next cycle", ai, ac, rc); end
    checks++; if (cmc !== 0 || dn !== 0) begin errors++; $display("FAIL ill_cache_activity: got %0d cmd cycles want 0", cmc); end
    checks++; if (ri !== 1 || f !== 1'b1 || rd !== '0) begin errors++; $display("FAIL ill_rsp: got idx %0d fault %b data %h want 1 1 0", ri, f, rd); end
  endtask

  task automatic test_timeout();
    int ai, ac, cc, rc, ri, dn, cmc; bit b2b; logic [DW-1:0] rd, di; logic f; logic [PIDW-1:0] pi;
    set_req(3, 2'b10, 12'h321, 4'd2);
    req_valid = 4'b1000;
    run_txn(1000000, 0, 1'b0, 1'b0, '0, ai, ac, cc, rc, ri, rd, f, dn, b2b, di, pi, cmc);
    checks++; if (rc < 0 || rc - cc !== TMO) begin errors++; $display("FAIL tmo_cycles: got %0d want %0d", rc - cc, TMO); end
    checks++; if (dn !== 0) begin errors++; $display("FAIL tmo_datavalid: got %0d want 0", dn); end
    checks++; if (ri !== 3 || f !== 1'b1 || rd !== '0) begin errors++; $display("FAIL tmo_rsp: got idx %0d fault %b data %h want 3 1 0", ri, f, rd); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int when[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    bit idle;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, (i % 2 == 0) ? 2'b10 : 2'b01, DW'(i + 1), PIDW'(i));
    c_wd = 1'b1; c_outvalid = 1'b1; c_pagefault = 1'b0; c_dataout = 12'h0C3;
    req_valid = '1;
    for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
      @(negedge clk);
      if (req_ack != '0) begin order.push_back(onehot_idx(req_ack)); when.push_back(cyc); end
    end
    @(posedge clk); #1 req_valid = '0;
    checks++; if (order.size() !== 6) begin errors++; $display("FAIL rr_count: got %0d grants want 6", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      checks++; if (order[i] !== exp_order[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]); end
      if (i > 0) begin
        checks++; if (when[i] - when[i-1] !== 4) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want 4", i, when[i] - when[i-1]); end
      end
    end
    idle = 1'b0;
    for (int cyc = 0; cyc < 20 && !idle; cyc++) begin @(negedge clk); idle = !busy; end
    checks++; if (!idle) begin errors++; $display("FAIL rr_drain: busy still 1 want 0"); end
    @(posedge clk); #1 c_wd = 1'b0; c_outvalid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int seen;
    bit saw_rsp, idle;
    do_reset();
    set_req(2, 2'b01, 12'h123, 4'd7);
    req_valid = 4'b0100;
    seen = 0; saw_rsp = 1'b0;
    for (int cyc = 0; cyc < 20 && seen < 3; cyc++) begin
      @(negedge clk);
      if (rsp_valid != '0) saw_rsp = 1'b1;
      if (c_cmd == 2'b01) seen++;
      @(posedge clk); #1 req_valid = '0;
    end
    checks++; if (seen !== 3) begin errors++; $display("FAIL mid_reach_wait: got %0d read cycles want 3", seen); end
    rst = 1'b1;
    @(negedge clk); if (rsp_valid != '0) saw_rsp = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ack, rsp_valid, rsp_data, rsp_fault, c_cmd, c_datain, c_pid, c_datavalid, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got cmd %b din %h busy %b rsp %h want all 0", c_cmd, c_datain, busy, rsp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(1, 2'b01, 12'h011, 4'd1);
    set_req(3, 2'b01, 12'h033, 4'd3);
    req_valid = 4'b1010;
    @(negedge clk);
    if (rsp_valid != '0) saw_rsp = 1'b1;
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b want 0010", req_ack); end
    checks++; if (saw_rsp) begin errors++; $display("FAIL mid_no_rsp: got rsp_valid pulse want none"); end
    @(posedge clk); #1 req_valid = '0; c_outvalid = 1'b1;
    idle = 1'b0;
    for (int cyc = 0; cyc < 20 && !idle; cyc++) begin @(negedge clk); idle = !busy; end
    checks++; if (!idle) begin errors++; $display("FAIL mid_drain: busy still 1 want 0"); end
    @(posedge clk); #1 c_outvalid = 1'b0;
  endtask

  task automatic test_random();
    int ptr, g, r, wdd, rdd;
    int ai, ac, cc, rc, ri, dn, cmc; bit b2b; logic [DW-1:0] rd, di; logic f; logic [PIDW-1:0] pi;
    logic [NREQ-1:0] mask;
    logic [1:0]      cmd_a  [NREQ];
    logic [DW-1:0]   data_a [NREQ];
    logic [PIDW-1:0] pid_a  [NREQ];
    logic [DW-1:0]   rdata, exp_data;
    logic            pf, ov, exp_fault;
    int              exp_dv;
    do_reset();
    ptr = 0;
    for (int t = 0; t < 40; t++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        r = $urandom % 8;
        cmd_a[i]  = (r < 3) ? 2'b10 : (r < 6) ? 2'b01 : (r == 6) ? 2'b11 : 2'b00;
        data_a[i] = DW'($urandom);
        pid_a[i]  = PIDW'($urandom);
        set_req(i, cmd_a[i], data_a[i], pid_a[i]);
      end
      g = -1;
      for (int i = 0; i < NREQ; i++) if (g < 0 && mask[(ptr + i) % NREQ]) g = (ptr + i) % NREQ;
      wdd = $urandom_range(0, 4); rdd = $urandom_range(0, 4);
      pf = ($urandom % 4 == 0); ov = !pf || ($urandom % 2 == 1);
      rdata = DW'($urandom);
      if (cmd_a[g] == 2'b10) begin exp_fault = 1'b0; exp_data = '0; exp_dv = 1; end
      else if (cmd_a[g] == 2'b01) begin exp_fault = pf; exp_data = pf ? '0 : rdata; exp_dv = 0; end
      else begin exp_fault = 1'b1; exp_data = '0; exp_dv = 0; end
      req_valid = mask;
      run_txn(wdd, rdd, pf, ov, rdata, ai, ac, cc, rc, ri, rd, f, dn, b2b, di, pi, cmc);
      req_valid = '0;
      checks++; if (ai !== g) begin errors++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", t, ai, g); end
      checks++; if (ri !== g || f !== exp_fault || rd !== exp_data) begin
        errors++; $display("FAIL rnd_rsp[%0d]: got idx %0d fault %b data %h want %0d %b %h", t, ri, f, rd, g, exp_fault, exp_data);
      end
      checks++; if (dn !== exp_dv || b2b) begin errors++; $display("FAIL rnd_datavalid[%0d]: got %0d want %0d", t, dn, exp_dv); end
      if (cmd_a[g] == 2'b10 || cmd_a[g] == 2'b01) begin
        checks++; if (di !== data_a[g] || pi !== pid_a[g]) begin
          errors++; $display("FAIL rnd_payload[%0d]: got %h/%h want %h/%h", t, di, pi, data_a[g], pid_a[g]);
        end
      end else begin
        checks++; if (cmc !== 0) begin errors++; $display("FAIL rnd_illegal_quiet[%0d]: got %0d cmd cycles want 0", t, cmc); end
      end
      ptr = (g + 1) % NREQ;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_hit();
    test_page_fault();
    test_illegal();
    test_timeout();
    test_round_robin();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Shares the single cache port (cmd/datain/PID/datavalid in; wd/pagefault/dataout/outvalid out) between NREQ independent requesters, one per process context.
- Grants requesters round-robin and sequences one transaction at a time through the cache's write handshake (wd/datavalid) or read handshake (outvalid/pagefault).
- Returns a one-cycle response to the owning requester.
- Sits between the process-side request sources and the cache.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 12, cache data/address width
PIDW, 4, process ID width
TMO, 255, max cycles waiting on cache before abort (8-bit counter)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  request pending, one bit per requester; held until accepted
req_cmd  in  2*NREQ  per requester: 2'b10 write, 2'b01 read, others illegal
req_data  in  DW*NREQ  per requester write data / read address
req_pid  in  PIDW*NREQ  per requester process ID
req_ack  out  NREQ  one-hot, 1-cycle pulse: request latched
rsp_valid  out  NREQ  one-hot, 1-cycle pulse: transaction finished
rsp_data  out  DW  read data (0 for writes/faults), valid with rsp_valid
rsp_fault  out  1  pagefault, illegal cmd or timeout, valid with rsp_valid
c_cmd  out  2  to cache cmd
c_datain  out  DW  to cache datain
c_pid  out  PIDW  to cache PID
c_datavalid  out  1  to cache datavalid
c_wd  in  1  cache ready for write data
c_pagefault  in  1  cache page fault
c_dataout  in  DW  cache read data
c_outvalid  in  1  cache read data valid
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset values: all outputs 0; c_cmd=2'b00; rr_ptr=0; state=IDLE; timeout counter=0. Reset mid-transaction aborts it silently: no rsp_valid is issued, and the requester must re-request.
- IDLE: if any req_valid, pick the first set bit scanning from rr_ptr upward with wrap. Same cycle: pulse req_ack[g]; latch cmd/data/pid into the owner register; set rr_ptr = g+1 mod NREQ. Next state by latched cmd:
  - 10 -> WR_WAIT
  - 01 -> RD_ISSUE
  - 00/11 -> RESP with fault=1
- Grant latency: one cycle from req_valid seen in IDLE to c_cmd driven.
- WR_WAIT: drive c_cmd=10, c_datain, c_pid. When c_wd=1, go to WR_PUSH.
- WR_PUSH: c_datavalid=1 for exactly one cycle, then RESP with fault=0, data=0.
  - c_datavalid is never asserted on two consecutive cycles.
- RD_ISSUE: drive c_cmd=01, c_datain=address, c_pid for one cycle, then RD_WAIT. Outputs are held.
- RD_WAIT: hold the cache inputs.
  - c_outvalid=1 -> RESP, data=c_dataout, fault=0.
  - c_pagefault=1 -> RESP, fault=1, data=0. Pagefault takes priority if both are asserted in the same cycle.
- Timeout: counter clears on entry to WR_WAIT/RD_WAIT and increments each waiting cycle. Reaching TMO -> RESP with fault=1, data=0.
- RESP: pulse rsp_valid[owner] with rsp_data/rsp_fault for one cycle; c_cmd=00; go to IDLE.
- Back-to-back throughput: an accepted request re-enters arbitration the cycle after RESP. Minimum spacing is 4 cycles for writes and 4 for reads with immediate cache response.
- req_valid deasserting after ack has no effect. A requester whose req_valid stays high after ack is treated as a new request.
- Only one transaction is outstanding at a time; no reordering.

Decomposition:
- Shared package holds:
  - command constants CMD_IDLE=2'b00, CMD_READ=2'b01, CMD_WRITE=2'b10
  - FSM state encoding (IDLE, WR_WAIT, WR_PUSH, RD_ISSUE, RD_WAIT, RESP)
- The cache module uses the same command constants.
- One sub-module: rr_arbiter (NREQ-bit request vector + pointer -> one-hot grant + index), purely combinational. The pointer register stays in the parent.

Test Plan:
- Single write: req0 cmd=10, data=12'd100, pid=4; cache wd=1 after 2 cycles -> req_ack[0] pulse; c_datavalid high exactly 1 cycle with c_datain=100, c_pid=4; rsp_valid[0], rsp_fault=0.
- Read hit: req2 cmd=01, addr=12'h05F, pid=5; c_outvalid with c_dataout=12'h3A7 after 3 cycles -> rsp_valid[2], rsp_data=12'h3A7, rsp_fault=0.
- Page fault: read with c_pagefault=1 and c_outvalid=1 in the same cycle -> rsp_fault=1, rsp_data=0.
- Round-robin fairness: all 4 requesters hold valid continuously with immediate cache responses -> grant order 0,1,2,3,0,1; no requester is starved.
- Timeout and illegal command:
  - wd held 0 -> rsp_fault=1 exactly TMO cycles after entering WR_WAIT; c_datavalid never asserted.
  - cmd=11 -> ack, then rsp_fault=1 with no cache activity.
- Reset mid-read: assert rst during RD_WAIT -> next cycle all outputs 0, no rsp_valid issued; after release, req1 pending is granted first (rr_ptr=0 scan).
